uart_tx_fifo: RTL and testbench

Buffered UART transmitter: byte writes from fabric logic go into a synchronous FIFO, and the block serialises them as 8N1 frames on uart_txd.
It is the transmit-side counterpart to the UART receive path feeding the 7-segment display logic.
It lets the top level queue bursts of bytes (echo, status strings) without per-byte handshaking against line timing.

---
 rtl/uart_pkg.sv | 12 +
 rtl/uart_tx_fifo_sync_fifo.sv | 50 +++++
 rtl/uart_tx_fifo.sv | 124 ++++++++++++
 tb/tb_uart_tx_fifo.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART transmit definitions: FSM states, frame shape and baud divisor.
package uart_pkg;
  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  // Rounded divisor; results below 2 are not supported by the transmitter.
  function automatic int calc_div(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction
endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Synchronous FIFO with head word always presented on dout while non-empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr, r_rd;
  logic [AW:0]      r_count;
  logic             w_push, w_pop;

  // Full blocks pushes even when a pop happens in the same cycle.
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  always_ff @(posedge sys_clk)
    if (w_push) r_mem[r_wr] <= din;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign dout  = r_mem[r_rd];
  assign full  = (r_count == (AW+1)'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;
endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: FIFO-fed frame FSM with back-to-back frames.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst_n,
  input  logic                          tx_send,
  input  logic [7:0]                    tx_data,
  output logic                          tx_full,
  output logic                          tx_empty,
  output logic [$clog2(FIFO_DEPTH):0]   tx_count,
  output logic                          tx_busy,
  output logic                          tx_overflow,
  output logic                          uart_txd
);
  localparam int DIV   = calc_div(CLK_FREQ, BAUD);
  localparam int CNT_W = $clog2(DIV * STOP_BITS);

  tx_state_t        r_state, w_state_n;
  logic [CNT_W-1:0] r_cnt, w_cnt_n;
  logic [7:0]       r_shift, w_shift_n;
  logic [2:0]       r_idx, w_idx_n;
  logic             r_txd, w_txd_n;
  logic             r_ovf;
  logic             w_pop;
  logic [7:0]       w_dout;
  logic             w_bit_end, w_stop_end;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .push      (tx_send),
    .pop       (w_pop),
    .din       (tx_data),
    .dout      (w_dout),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count)
  );

  assign w_bit_end  = (r_cnt == CNT_W'(DIV - 1));
  assign w_stop_end = (r_cnt == CNT_W'(DIV * STOP_BITS - 1));

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_shift_n = r_shift;
    w_idx_n   = r_idx;
    w_pop     = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_n = '0;
        if (!tx_empty) begin
          w_pop     = 1'b1;
          w_shift_n = w_dout;
          w_state_n = START;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_cnt_n   = '0;
          w_idx_n   = '0;
          w_state_n = DATA;
        end else w_cnt_n = r_cnt + 1'b1;
      end
      DATA: begin
        if (w_bit_end) begin
          w_cnt_n   = '0;
          w_shift_n = r_shift >> 1;
          w_idx_n   = r_idx + 3'd1;
          if (r_idx == 3'(DATA_BITS - 1)) w_state_n = STOP;
        end else w_cnt_n = r_cnt + 1'b1;
      end
      STOP: begin
        if (w_stop_end) begin
          w_cnt_n = '0;
          // Chain straight into the next frame so queued bytes leave with no idle gap.
          if (!tx_empty) begin
            w_pop     = 1'b1;
            w_shift_n = w_dout;
            w_state_n = START;
          end else w_state_n = IDLE;
        end else w_cnt_n = r_cnt + 1'b1;
      end
      default: w_state_n = IDLE;
    endcase
  end

  // Line level is decoded from the next state so uart_txd comes straight off a flop.
  always_comb begin
    w_txd_n = 1'b1;
    case (w_state_n)
      START:   w_txd_n = 1'b0;
      DATA:    w_txd_n = w_shift_n[0];
      default: w_txd_n = 1'b1;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_idx   <= '0;
      r_txd   <= 1'b1;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_shift <= w_shift_n;
      r_idx   <= w_idx_n;
      r_txd   <= w_txd_n;
      r_ovf   <= tx_send & tx_full;
    end
  end

  assign uart_txd    = r_txd;
  assign tx_busy     = (r_state != IDLE);
  assign tx_overflow = r_ovf;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: frame decoder scoreboard plus cycle-exact spot checks.
module tb_uart_tx_fifo;
  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int DEPTH    = 4;
  localparam int DIV      = 10;

  logic       sys_clk, sys_rst_n, tx_send;
  logic [7:0] tx_data;
  logic       tx_full, tx_empty, tx_busy, tx_overflow, uart_txd;
  logic [2:0] tx_count;

  int         n_cmp = 0, n_fail = 0;
  int         cyc = 0;
  int         last_e;
  bit         mon_en = 1'b1;
  logic [7:0] exp_q[$];

  uart_tx_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .tx_send     (tx_send),
    .tx_data     (tx_data),
    .tx_full     (tx_full),
    .tx_empty    (tx_empty),
    .tx_count    (tx_count),
    .tx_busy     (tx_busy),
    .tx_overflow (tx_overflow),
    .uart_txd    (uart_txd)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Samples are taken on negedges, i.e. the state after posedge number cyc.
  task automatic at(input int t);
    while (cyc < t) @(negedge sys_clk);
  endtask

  task automatic drive(input logic [7:0] b, input bit acc);
    @(negedge sys_clk);
    tx_send = 1'b1;
    tx_data = b;
    if (acc) exp_q.push_back(b);
    last_e = cyc + 1;
  endtask

  task automatic release_send;
    @(negedge sys_clk);
    tx_send = 1'b0;
  endtask

  // Frame decoder: samples mid-bit after each detected falling edge.
  initial begin
    logic       prev;
    logic [7:0] b;
    prev = 1'b1;
    forever begin
      @(negedge sys_clk);
      if (mon_en && sys_rst_n && prev && !uart_txd) begin
        repeat (DIV / 2) @(negedge sys_clk);
        check("rx_start_bit", uart_txd, 0);
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge sys_clk);
          b[i] = uart_txd;
        end
        repeat (DIV) @(negedge sys_clk);
        check("rx_stop_bit", uart_txd, 1);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL rx_extra_frame: got byte %0h expected no frame", b);
        end else check("rx_byte", b, exp_q.pop_front());
      end
      prev = uart_txd;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within cycle budget");
    $fatal(1);
  end

  initial begin
    int e0, lows;
    sys_rst_n = 1'b0;
    tx_send   = 1'b0;
    tx_data   = 8'h00;

    // 1: reset and idle
    repeat (5) @(negedge sys_clk);
    check("rst_txd", uart_txd, 1);
    check("rst_count", tx_count, 0);
    check("rst_empty", tx_empty, 1);
    check("rst_full", tx_full, 0);
    sys_rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge sys_clk);
      check("idle_txd", uart_txd, 1);
      check("idle_empty", tx_empty, 1);
      check("idle_count", tx_count, 0);
      check("idle_busy", tx_busy, 0);
      check("idle_ovf", tx_overflow, 0);
    end

    // 2: single 0x55 frame, exact bit timing
    drive(8'h55, 1);
    e0 = last_e;
    release_send;
    check("t2_count_after_push", tx_count, 1);
    check("t2_txd_before_pop", uart_txd, 1);
    at(e0 + 1);
    check("t2_start_fall", uart_txd, 0);
    check("t2_count_after_pop", tx_count, 0);
    check("t2_busy", tx_busy, 1);
    at(e0 + 10);  check("t2_start_end", uart_txd, 0);
    at(e0 + 11);  check("t2_bit0", uart_txd, 1);
    at(e0 + 21);  check("t2_bit1", uart_txd, 0);
    at(e0 + 81);  check("t2_bit7", uart_txd, 0);
    at(e0 + 91);  check("t2_stop", uart_txd, 1);
    at(e0 + 100); check("t2_busy_last_stop", tx_busy, 1);
    at(e0 + 101); check("t2_busy_fall", tx_busy, 0);
    check("t2_txd_idle", uart_txd, 1);
    repeat (10) @(negedge sys_clk);
    check("t2_frames_left", exp_q.size(), 0);

    // 3: three back-to-back frames
    drive(8'h11, 1);
    e0 = last_e;
    drive(8'hA5, 1);
    check("t3_count0", tx_count, 1);
    drive(8'hFF, 1);
    check("t3_count1", tx_count, 1);
    release_send;
    check("t3_count2", tx_count, 2);
    at(e0 + 100); check("t3_f1_stop", uart_txd, 1); check("t3_cnt_f1", tx_count, 2);
    at(e0 + 101); check("t3_f2_start", uart_txd, 0); check("t3_cnt_f2", tx_count, 1);
    at(e0 + 200); check("t3_f2_stop", uart_txd, 1);
    at(e0 + 201); check("t3_f3_start", uart_txd, 0); check("t3_cnt_f3", tx_count, 0);
    at(e0 + 300); check("t3_busy_f3", tx_busy, 1);
    at(e0 + 301); check("t3_busy_fall", tx_busy, 0);
    check("t3_frames_left", exp_q.size(), 0);

    // 4: overflow on the sixth push
    repeat (5) @(negedge sys_clk);
    drive(8'h01, 1);
    e0 = last_e;
    drive(8'h02, 1);
    drive(8'h03, 1);
    drive(8'h04, 1);
    drive(8'h05, 1);
    drive(8'h06, 0);
    check("t4_full", tx_full, 1);
    check("t4_count_full", tx_count, 4);
    release_send;
    check("t4_ovf_pulse", tx_overflow, 1);
    check("t4_count_kept", tx_count, 4);
    @(negedge sys_clk);
    check("t4_ovf_clear", tx_overflow, 0);
    at(e0 + 510);
    check("t4_busy_done", tx_busy, 0);
    check("t4_empty_done", tx_empty, 1);
    check("t4_frames_left", exp_q.size(), 0);

    // 5: reset during data bit 3 of 0xC3 with two bytes queued
    mon_en = 1'b0;
    drive(8'hC3, 0);
    e0 = last_e;
    drive(8'h01, 0);
    drive(8'h02, 0);
    release_send;
    at(e0 + 45);
    check("t5_count_before", tx_count, 2);
    check("t5_bit3", uart_txd, 0);
    #2 sys_rst_n = 1'b0;
    #1;
    check("t5_async_txd", uart_txd, 1);
    check("t5_async_count", tx_count, 0);
    check("t5_async_busy", tx_busy, 0);
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    lows = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge sys_clk);
      if (!uart_txd) lows++;
    end
    check("t5_no_restart", lows, 0);
    check("t5_empty", tx_empty, 1);
    mon_en = 1'b1;

    // 6: push during STOP chains directly into the next START
    drive(8'hAA, 1);
    e0 = last_e;
    release_send;
    at(e0 + 94);
    drive(8'h3C, 1);
    release_send;
    at(e0 + 100);
    check("t6_stop_txd", uart_txd, 1);
    check("t6_count_queued", tx_count, 1);
    at(e0 + 101);
    check("t6_start_txd", uart_txd, 0);
    check("t6_busy", tx_busy, 1);
    check("t6_count_popped", tx_count, 0);
    at(e0 + 206);
    check("t6_busy_done", tx_busy, 0);
    check("t6_frames_left", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
